pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM measurement block: the receiving end of the team's fixed-frame PWM generator. Samples an asynchronous PWM pin, measures high time and period of each cycle in clock counts, and publishes one registered result per period. Detects stuck-high and stuck-low lines by timeout. Sits behind the tapeout top wrapper, which maps io_in/io_out pins to these ports.

## Interface
- CNT_W, 6: width of all counters and the duty/period result fields.
- MAX_PERIOD, 63: largest measurable period in clocks; must be ≤ 2**CNT_W-1 and ≥ 2.
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM line.
- duty  output  CNT_W  high-time cycles of last measured period.
- period  output  CNT_W  rise-to-rise cycles of last measured period; 0 on stuck report.
- valid  output  1  one-cycle strobe; duty/period/stuck/level updated this cycle.
- stuck  output  1  last report was a timeout (no rising edge within MAX_PERIOD).
- level  output  1  synchronized line level at timeout; meaningful only when stuck=1.

## Operation
- Synchronizer: two flops (sync1, s), then s_d = s delayed one cycle. rise = s & ~s_d. All three reset to 1, so a line already high at reset produces no spurious rise.
- Counters: per_cnt and hi_cnt, CNT_W bits each, reset to 0.
- States: IDLE (no reference rise yet) and MEAS (inside a period). Reset -> IDLE.
- IDLE: per_cnt increments each cycle. hi_cnt is held at 0.
  - On rise: per_cnt <= 1, hi_cnt <= 1, go MEAS. No report.
- MEAS, no rise: per_cnt += 1; hi_cnt += s.
- MEAS, rise: publish duty <= hi_cnt, period <= per_cnt, stuck <= 0, level <= 0, valid <= 1. Reload per_cnt <= 1, hi_cnt <= 1. Stay MEAS.
- Timeout (either state, per_cnt == MAX_PERIOD and no rise this cycle): publish duty <= 0, period <= 0, stuck <= 1, level <= s, valid <= 1. Then per_cnt <= 0, hi_cnt <= 0, go IDLE.
  - A constant line therefore reports stuck every MAX_PERIOD+1 cycles.
- Priority: reset > rise > timeout > count.
- Counters never wrap: timeout fires before per_cnt can exceed MAX_PERIOD. hi_cnt ≤ per_cnt always.
- Duty 100% (line never falls) is indistinguishable from stuck-high and is reported as stuck, level=1.
- Reset mid-period discards the partial measurement. The first report after reset needs two rises, or a timeout.

## Timing
- Reset values: duty=0, period=0, valid=0, stuck=0, level=0, state IDLE.
- All outputs are registered. valid is high for exactly one cycle. duty/period/stuck/level hold until the next report.
- Pin-to-report latency: pin rise captured at clock edge k into sync1, appears on s after edge k+1, and is reported with valid=1 after edge k+2.
  - Rise and fall pass through the same two-stage pipe, so measured widths are exact for a pin that is stable across clock edges.
- Minimum measurable period 2 (one high, one low). A 1-cycle high pulse gives duty=1.
- Timeout report: valid after the edge at which per_cnt would have reached MAX_PERIOD+1.

## Structure
- Package pwm_capture_pkg:
  - state enum {IDLE, MEAS};
  - default CNT_W and MAX_PERIOD constants, shared with the generator's frame length of 50 so both ends agree on sizing.
- Sub-module pwm_edge_sync: 2-flop synchronizer plus s_d register. Outputs s and rise, with reset value 1. It is reusable by other pin-capture blocks.
- Top level: state register, the two counters, result registers.

## Test plan
- 50-cycle frame, 25 high / 25 low, repeated:
  - no report for the first period;
  - then valid every 50 cycles with duty=25, period=50, stuck=0.
- 10 high / 40 low: steady reports duty=10, period=50.
- Line held high from reset (generator duty ≥ 50): no rise, so per_cnt runs in IDLE. valid with stuck=1, level=1, duty=0, period=0 after 64 cycles, repeating every 64 cycles.
  - Held low: same cadence, level=0.
- Frame of period 63 (1 high): reports duty=1, period=63.
  - Period 64: timeout fires, and the rise arriving on the next cycle starts a fresh measurement.
- Reset asserted for one cycle mid-period of a 25/25 stream:
  - outputs read all-zero on the cycle after;
  - the first post-reset report is duty=25, period=50, one full period after the first post-reset rise.
- Rise coincident with per_cnt==MAX_PERIOD: normal report (stuck=0, period=63); no timeout report that cycle.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared sizing and state encoding for the PWM capture block.
// Defaults match the generator's 50-cycle frame with headroom to 63.
package pwm_capture_pkg;

  localparam int CNT_W_DEF      = 6;
  localparam int MAX_PERIOD_DEF = 63;
  localparam int FRAME_LEN      = 50;

  typedef enum logic {
    IDLE,
    MEAS
  } state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop pin synchronizer plus a delay stage for rising-edge detect.
// All stages reset high so a line already high at reset gives no rise.
module pwm_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic s,
  output logic rise
);

  logic sync1_d, sync1_q;
  logic s_d, s_q;
  logic s_dly_d, s_dly_q;

  always_comb begin
    sync1_d = pin;
    s_d     = sync1_q;
    s_dly_d = s_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      s_dly_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign s    = s_q;
  assign rise = s_q & ~s_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of each PWM cycle in clock counts,
// reporting stuck-high/low lines when no rise arrives in time.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_PERIOD = MAX_PERIOD_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             stuck,
  output logic             level
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic s;
  logic rise;
  logic tmo;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] per_cnt_d, per_cnt_q;
  logic [CNT_W-1:0] hi_cnt_d, hi_cnt_q;
  logic [CNT_W-1:0] duty_d, duty_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic             valid_d, valid_q;
  logic             stuck_d, stuck_q;
  logic             level_d, level_q;

  pwm_edge_sync u_sync (
    .clock (clock),
    .reset (reset),
    .pin   (pwm_in),
    .s     (s),
    .rise  (rise)
  );

  // A rise on the final count is a valid period, not a timeout.
  assign tmo = (per_cnt_q == MAX_CNT) & ~rise;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;
    level_d   = level_q;
    unique case (1'b1)
      rise: begin
        per_cnt_d = ONE;
        hi_cnt_d  = ONE;
        state_d   = MEAS;
        if (state_q == MEAS) begin
          duty_d   = hi_cnt_q;
          period_d = per_cnt_q;
          stuck_d  = 1'b0;
          level_d  = 1'b0;
          valid_d  = 1'b1;
        end
      end
      tmo: begin
        duty_d    = '0;
        period_d  = '0;
        stuck_d   = 1'b1;
        level_d   = s;
        valid_d   = 1'b1;
        per_cnt_d = '0;
        hi_cnt_d  = '0;
        state_d   = IDLE;
      end
      default: begin
        per_cnt_d = per_cnt_q + ONE;
        if (state_q == MEAS) begin
          hi_cnt_d = hi_cnt_q + CNT_W'(s);
        end else begin
          hi_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      stuck_q   <= stuck_d;
      level_q   <= level_d;
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;
  assign level  = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench: scenarios queue expected reports, a monitor
// pops and compares one entry per valid strobe.
module tb_pwm_capture;

  logic       clock;
  logic       reset;
  logic       pwm_in;
  logic [5:0] duty;
  logic [5:0] period;
  logic       valid;
  logic       stuck;
  logic       level;

  typedef struct packed {
    logic [5:0] duty;
    logic [5:0] period;
    logic       stuck;
    logic       level;
  } rep_t;

  rep_t exp_q[$];
  int   checks;
  int   errors;

  pwm_capture dut (
    .clock  (clock),
    .reset  (reset),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .stuck  (stuck),
    .level  (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_report: got duty=%0d period=%0d stuck=%0d level=%0d, expected none",
                 duty, period, stuck, level);
      end else begin
        rep_t e;
        e = exp_q.pop_front();
        if (duty !== e.duty || period !== e.period ||
            stuck !== e.stuck || level !== e.level) begin
          errors++;
          $display("FAIL report: got duty=%0d period=%0d stuck=%0d level=%0d, expected duty=%0d period=%0d stuck=%0d level=%0d",
                   duty, period, stuck, level,
                   e.duty, e.period, e.stuck, e.level);
        end
      end
    end
  end

  task automatic push(input int d, input int p, input int st, input int lv, input int n);
    rep_t r;
    r.duty   = 6'(d);
    r.period = 6'(p);
    r.stuck  = 1'(st);
    r.level  = 1'(lv);
    for (int i = 0; i < n; i++) exp_q.push_back(r);
  endtask

  task automatic frame(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      repeat (h) @(negedge clock);
      pwm_in = 1'b0;
      repeat (p - h) @(negedge clock);
    end
  endtask

  task automatic do_reset(input logic lv);
    pwm_in = lv;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (10) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d reports outstanding, expected 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (duty !== 6'd0 || period !== 6'd0 || valid !== 1'b0 ||
        stuck !== 1'b0 || level !== 1'b0) begin
      errors++;
      $display("FAIL %s: got duty=%0d period=%0d valid=%0d stuck=%0d level=%0d, expected all 0",
               name, duty, period, valid, stuck, level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_zero("reset_state");

    // 25/25: first period silent, then one report per rise
    push(25, 50, 0, 0, 4);
    repeat (3) @(negedge clock);
    frame(25, 50, 5);
    drain("25_25");

    // 10/40
    do_reset(1'b0);
    push(10, 50, 0, 0, 3);
    repeat (3) @(negedge clock);
    frame(10, 50, 4);
    drain("10_40");

    // held high from reset: timeout every 64 cycles
    do_reset(1'b1);
    push(0, 0, 1, 1, 3);
    repeat (212) @(negedge clock);
    drain("stuck_high");

    // held low
    do_reset(1'b0);
    push(0, 0, 1, 0, 3);
    repeat (212) @(negedge clock);
    drain("stuck_low");

    // period 63, rise lands on max count; trailing idle times out
    do_reset(1'b0);
    push(1, 63, 0, 0, 3);
    push(0, 0, 1, 0, 1);
    repeat (3) @(negedge clock);
    frame(1, 63, 4);
    drain("period_63");

    // period 64: every frame times out one cycle before its next rise
    do_reset(1'b0);
    push(0, 0, 1, 0, 4);
    repeat (3) @(negedge clock);
    frame(1, 64, 4);
    drain("period_64");

    // one-cycle reset mid-period discards the partial measurement
    do_reset(1'b0);
    push(25, 50, 0, 0, 4);
    repeat (3) @(negedge clock);
    frame(25, 50, 2);
    pwm_in = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_zero("mid_reset_zero");
    repeat (14) @(negedge clock);
    pwm_in = 1'b0;
    repeat (25) @(negedge clock);
    frame(25, 50, 3);
    drain("mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
